// File: rtl/counter_pkg.sv
// ---- counter_pkg : shared types for the counter driver (rev 1.0) ----
`default_nettype none
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    RESP   = 2'd2
  } state_e;

  // A zero delay would make the counter wrap to its full range.
  localparam int unsigned c_min_cycles = 1;

endpackage
`default_nettype wire

// File: rtl/counter_driver_fifo.sv
// ---- counter_driver_fifo : els_p-deep request FIFO, valid/ready push, head peek + pop (rev 1.0) ----
`default_nettype none
module counter_driver_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int c_ptr_w = $clog2(els_p);
  localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(els_p);

  logic [width_p-1:0] mem_q [els_p];
  logic [c_ptr_w-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [c_ptr_w:0]   cnt_q, cnt_d;
  logic               push_w, pop_w;

  assign ready_o = (cnt_q != c_full);
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign push_w  = v_i & ready_o;
  assign pop_w   = yumi_i & v_o;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push_w) wr_d = wr_q + 1'b1;
    if (pop_w)  rd_d = rd_q + 1'b1;
    if (push_w && !pop_w)      cnt_d = cnt_q + 1'b1;
    else if (pop_w && !push_w) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the occupancy count decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_w) mem_q[wr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/counter_driver.sv
// ---- counter_driver : issues buffered requests to the delay counter, checks and times the results (rev 1.0) ----
`default_nettype none
module counter_driver
  import counter_pkg::*;
#(
  parameter int cycles_width_p = 8,
  parameter int width_p        = 8,
  parameter int els_p          = 4,
  parameter int stat_width_p   = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      in_v_i,
  output logic                      in_ready_o,
  input  logic [cycles_width_p-1:0] in_cycles_i,
  input  logic [width_p-1:0]        in_data_i,
  output logic                      cnt_v_o,
  output logic [cycles_width_p-1:0] cnt_cycles_o,
  output logic [width_p-1:0]        cnt_data_o,
  input  logic                      cnt_yumi_i,
  input  logic                      ret_v_i,
  input  logic [width_p-1:0]        ret_data_i,
  output logic                      ret_ready_o,
  output logic                      out_v_o,
  output logic [width_p-1:0]        out_data_o,
  output logic [stat_width_p-1:0]   out_latency_o,
  input  logic                      out_ready_i,
  output logic                      err_o,
  output logic [stat_width_p-1:0]   issued_o,
  output logic [stat_width_p-1:0]   done_o,
  output logic [stat_width_p-1:0]   max_lat_o
);

  typedef struct packed {
    logic [cycles_width_p-1:0] cycles;
    logic [width_p-1:0]        data;
  } req_t;

  req_t push_req_w, head_w;
  logic fifo_v_w;

  state_e state_q, state_d;

  logic [width_p-1:0]      expect_q, expect_d;
  logic [stat_width_p-1:0] elapsed_q, elapsed_d;
  logic [width_p-1:0]      out_data_q, out_data_d;
  logic [stat_width_p-1:0] out_lat_q, out_lat_d;
  logic                    err_q, err_d;
  logic [stat_width_p-1:0] issued_q, issued_d, done_q, done_d, max_q, max_d;
  logic [stat_width_p-1:0] lat_w;
  logic                    issue_w, ret_fire_w, out_fire_w;

  always_comb begin
    push_req_w.cycles = (in_cycles_i == '0) ? cycles_width_p'(c_min_cycles) : in_cycles_i;
    push_req_w.data   = in_data_i;
  end

  counter_driver_fifo #(
    .width_p ($bits(req_t)),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (in_v_i),
    .data_i  (push_req_w),
    .ready_o (in_ready_o),
    .v_o     (fifo_v_w),
    .data_o  (head_w),
    .yumi_i  (issue_w)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_yumi_i && fifo_v_w) state_d = ISSUED;
      ISSUED:  if (ret_v_i)                state_d = RESP;
      RESP:    if (out_ready_i)            state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Head fields are gated so stale FIFO storage never reaches the counter.
  always_comb begin
    cnt_v_o      = (state_q == IDLE) && fifo_v_w;
    cnt_cycles_o = cnt_v_o ? head_w.cycles : '0;
    cnt_data_o   = cnt_v_o ? head_w.data   : '0;
    ret_ready_o  = (state_q == ISSUED);
    out_v_o      = (state_q == RESP);
  end

  assign issue_w    = cnt_yumi_i & cnt_v_o;
  assign ret_fire_w = ret_v_i & ret_ready_o;
  assign out_fire_w = out_v_o & out_ready_i;
  assign lat_w      = (&elapsed_q) ? elapsed_q : elapsed_q + 1'b1;

  always_comb begin
    expect_d   = expect_q;
    elapsed_d  = elapsed_q;
    out_data_d = out_data_q;
    out_lat_d  = out_lat_q;
    err_d      = err_q;
    issued_d   = issued_q;
    done_d     = done_q;
    max_d      = max_q;
    if (issue_w) begin
      expect_d  = head_w.data;
      elapsed_d = '0;
      issued_d  = issued_q + 1'b1;
    end else if (ret_ready_o && !(&elapsed_q)) begin
      elapsed_d = elapsed_q + 1'b1;
    end
    if (ret_fire_w) begin
      out_data_d = ret_data_i;
      out_lat_d  = lat_w;
      if (ret_data_i != expect_q) err_d = 1'b1;
      if (lat_w > max_q)          max_d = lat_w;
    end
    if (out_fire_w) done_d = done_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      expect_q   <= '0;
      elapsed_q  <= '0;
      out_data_q <= '0;
      out_lat_q  <= '0;
      err_q      <= 1'b0;
      issued_q   <= '0;
      done_q     <= '0;
      max_q      <= '0;
    end else begin
      expect_q   <= expect_d;
      elapsed_q  <= elapsed_d;
      out_data_q <= out_data_d;
      out_lat_q  <= out_lat_d;
      err_q      <= err_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      max_q      <= max_d;
    end
  end

  assign out_data_o    = out_data_q;
  assign out_latency_o = out_lat_q;
  assign err_o         = err_q;
  assign issued_o      = issued_q;
  assign done_o        = done_q;
  assign max_lat_o     = max_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_driver.sv
// ---- tb_counter_driver : bench for counter_driver with a behavioural delay counter (rev 1.0) ----
`default_nettype none
`timescale 1ns/1ps
module tb_counter_driver;

  localparam int CW  = 4;
  localparam int W   = 8;
  localparam int ELS = 4;
  localparam int SW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_v, in_ready;
  logic [CW-1:0] in_cycles;
  logic [W-1:0]  in_data;
  logic          cnt_v, cnt_yumi;
  logic [CW-1:0] cnt_cycles;
  logic [W-1:0]  cnt_data;
  logic          ret_v, ret_ready;
  logic [W-1:0]  ret_data;
  logic          out_v, out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_lat, issued, done, max_lat;
  logic          err;

  always #5 clk = ~clk;

  counter_driver #(
    .cycles_width_p (CW),
    .width_p        (W),
    .els_p          (ELS),
    .stat_width_p   (SW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .in_v_i        (in_v),
    .in_ready_o    (in_ready),
    .in_cycles_i   (in_cycles),
    .in_data_i     (in_data),
    .cnt_v_o       (cnt_v),
    .cnt_cycles_o  (cnt_cycles),
    .cnt_data_o    (cnt_data),
    .cnt_yumi_i    (cnt_yumi),
    .ret_v_i       (ret_v),
    .ret_data_i    (ret_data),
    .ret_ready_o   (ret_ready),
    .out_v_o       (out_v),
    .out_data_o    (out_data),
    .out_latency_o (out_lat),
    .out_ready_i   (out_ready),
    .err_o         (err),
    .issued_o      (issued),
    .done_o        (done),
    .max_lat_o     (max_lat)
  );

  // Delay counter: result handshake lands cycles+1 edges after the accept edge.
  logic ctr_busy, fault, yumi_en;
  int   ctr_rem;
  assign cnt_yumi = cnt_v & yumi_en & ~ctr_busy;

  always @(posedge clk) begin
    if (reset) begin
      ctr_busy <= 1'b0;
      ret_v    <= 1'b0;
      ctr_rem  <= 0;
      ret_data <= '0;
    end else if (!ctr_busy) begin
      if (cnt_yumi) begin
        ctr_busy <= 1'b1;
        ctr_rem  <= int'(cnt_cycles);
        ret_data <= cnt_data ^ {{(W-1){1'b0}}, fault};
      end
    end else if (ret_v) begin
      if (ret_ready) begin
        ret_v    <= 1'b0;
        ctr_busy <= 1'b0;
      end
    end else if (ctr_rem <= 1) begin
      ret_v <= 1'b1;
    end else begin
      ctr_rem <= ctr_rem - 1;
    end
  end

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] lat;
  } resp_t;

  resp_t mon_q[$];
  resp_t exp_q[$];

  always begin
    @(negedge clk);
    #2;
    if (reset === 1'b0 && out_v === 1'b1 && out_ready === 1'b1)
      mon_q.push_back('{out_data, out_lat});
  end

  int unsigned   errors = 0, checks = 0;
  int unsigned   exp_issued = 0, exp_done = 0;
  logic [SW-1:0] exp_max = '0;
  logic          exp_err = 1'b0;

  task automatic push(input int c, input logic [W-1:0] d);
    resp_t e;
    int    t = 0;
    while (in_ready !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL push_timeout in_ready=%b after %0d cycles", in_ready, t);
      return;
    end
    in_v = 1'b1; in_cycles = CW'(c); in_data = d;
    @(negedge clk);
    in_v = 1'b0;
    e.data = d ^ {{(W-1){1'b0}}, fault};
    e.lat  = SW'(((c == 0) ? 1 : c) + 1);
    exp_q.push_back(e);
    exp_issued++;
    if (e.lat > exp_max) exp_max = e.lat;
    if (fault) exp_err = 1'b1;
  endtask

  task automatic wait_resp(input int n, output bit ok);
    int t = 0;
    while (mon_q.size() < n && t < 3000) begin @(negedge clk); t++; end
    ok = (mon_q.size() >= n);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; in_v = 1'b0; in_cycles = '0; in_data = '0;
    out_ready = 1'b1; yumi_en = 1'b1; fault = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cnt_v, cnt_cycles, cnt_data, ret_ready, out_v, out_data, out_lat, err, issued, done, max_lat} !== '0
        || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_during in_ready=%b cnt_v=%b out_v=%b issued=%0d done=%0d err=%b need all 0, in_ready=1",
               in_ready, cnt_v, out_v, issued, done, err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cnt_v, ret_ready, out_v, out_data, out_lat, err, issued, done, max_lat} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after in_ready=%b cnt_v=%b out_v=%b need idle outputs", in_ready, cnt_v, out_v);
    end
  endtask

  task automatic test_single;
    bit ok; resp_t o, e;
    push(5, 8'hA5);
    wait_resp(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got=%0d need=1", mon_q.size()); end
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      o = mon_q.pop_front(); e = exp_q.pop_front(); exp_done++;
      checks++;
      if (o.data !== e.data || o.lat !== e.lat) begin
        errors++;
        $display("FAIL single_resp data=%h lat=%0d need data=%h lat=%0d", o.data, o.lat, e.data, e.lat);
      end
    end
    checks++;
    if (issued !== SW'(exp_issued) || done !== SW'(exp_done) || err !== 1'b0) begin
      errors++;
      $display("FAIL single_stats issued=%0d done=%0d err=%b need %0d %0d 0", issued, done, err, exp_issued, exp_done);
    end
  endtask

  task automatic test_zero_cycles;
    bit ok; resp_t o, e;
    yumi_en = 1'b0;
    push(0, 8'h11);
    checks++;
    if (cnt_v !== 1'b1 || cnt_cycles !== CW'(1) || cnt_data !== 8'h11) begin
      errors++;
      $display("FAIL zero_offer cnt_v=%b cnt_cycles=%0d cnt_data=%h need 1 1 11", cnt_v, cnt_cycles, cnt_data);
    end
    yumi_en = 1'b1;
    wait_resp(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout got=%0d need=1", mon_q.size()); end
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      o = mon_q.pop_front(); e = exp_q.pop_front(); exp_done++;
      checks++;
      if (o.data !== e.data || o.lat !== e.lat) begin
        errors++;
        $display("FAIL zero_resp data=%h lat=%0d need data=%h lat=%0d", o.data, o.lat, e.data, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok; resp_t o, e;
    yumi_en = 1'b0;
    for (int i = 0; i < 3; i++) push($urandom_range(0, 9), W'($urandom));
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready3 in_ready=%b need 1", in_ready); end
    push($urandom_range(0, 9), W'($urandom));
    checks++;
    if (in_ready !== 1'b0 || cnt_v !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full in_ready=%b cnt_v=%b need 0 1", in_ready, cnt_v);
    end
    yumi_en = 1'b1;
    push($urandom_range(0, 9), W'($urandom));
    wait_resp(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout got=%0d need=5", mon_q.size()); end
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      o = mon_q.pop_front(); e = exp_q.pop_front(); exp_done++;
      checks++;
      if (o.data !== e.data || o.lat !== e.lat) begin
        errors++;
        $display("FAIL b2b_resp data=%h lat=%0d need data=%h lat=%0d", o.data, o.lat, e.data, e.lat);
      end
    end
    checks++;
    if (done !== SW'(exp_done)) begin errors++; $display("FAIL b2b_done done=%0d need %0d", done, exp_done); end
  endtask

  task automatic test_stall;
    bit ok; resp_t o, e;
    int t = 0;
    out_ready = 1'b0;
    push(3, 8'h5A);
    push(2, 8'hC3);
    while (out_v !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_v !== 1'b1 || out_data !== 8'h5A || out_lat !== SW'(4) || ret_ready !== 1'b0 ||
          cnt_v !== 1'b0 || issued !== SW'(exp_issued - 1)) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d out_v=%b data=%h lat=%0d ret_ready=%b cnt_v=%b issued=%0d need 1 5a 4 0 0 %0d",
                 i, out_v, out_data, out_lat, ret_ready, cnt_v, issued, exp_issued - 1);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_resp(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout got=%0d need=2", mon_q.size()); end
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      o = mon_q.pop_front(); e = exp_q.pop_front(); exp_done++;
      checks++;
      if (o.data !== e.data || o.lat !== e.lat) begin
        errors++;
        $display("FAIL stall_resp data=%h lat=%0d need data=%h lat=%0d", o.data, o.lat, e.data, e.lat);
      end
    end
  endtask

  task automatic test_random;
    bit ok, stop; resp_t o, e;
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) push($urandom_range(0, 9), W'($urandom));
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          yumi_en   = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1; yumi_en = 1'b1;
    wait_resp(24, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL random_timeout got=%0d need=24", mon_q.size()); end
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      o = mon_q.pop_front(); e = exp_q.pop_front(); exp_done++;
      checks++;
      if (o.data !== e.data || o.lat !== e.lat) begin
        errors++;
        $display("FAIL random_resp data=%h lat=%0d need data=%h lat=%0d", o.data, o.lat, e.data, e.lat);
      end
    end
    checks++;
    if (issued !== SW'(exp_issued) || done !== SW'(exp_done) || max_lat !== exp_max || err !== exp_err) begin
      errors++;
      $display("FAIL random_stats issued=%0d done=%0d max=%0d err=%b need %0d %0d %0d %b",
               issued, done, max_lat, err, exp_issued, exp_done, exp_max, exp_err);
    end
  endtask

  task automatic test_fault;
    bit ok; resp_t o, e;
    fault = 1'b1;
    push(4, 8'h3C);
    wait_resp(1, ok);
    fault = 1'b0;
    push(2, 8'h55);
    wait_resp(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fault_timeout got=%0d need=2", mon_q.size()); end
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      o = mon_q.pop_front(); e = exp_q.pop_front(); exp_done++;
      checks++;
      if (o.data !== e.data || o.lat !== e.lat) begin
        errors++;
        $display("FAIL fault_resp data=%h lat=%0d need data=%h lat=%0d", o.data, o.lat, e.data, e.lat);
      end
    end
    checks++;
    if (err !== 1'b1 || done !== SW'(exp_done)) begin
      errors++;
      $display("FAIL fault_sticky err=%b done=%0d need 1 %0d", err, done, exp_done);
    end
  endtask

  task automatic test_reset_mid;
    bit ok; resp_t o, e;
    int t = 0;
    push(12, 8'h77);
    push(3, 8'h12);
    while (ret_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (ret_ready !== 1'b1) begin errors++; $display("FAIL rmid_issue ret_ready=%b need 1", ret_ready); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cnt_v, cnt_cycles, cnt_data, ret_ready, out_v, out_data, out_lat, err, issued, done, max_lat} !== '0
        || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_outputs in_ready=%b cnt_v=%b ret_ready=%b err=%b issued=%0d need all 0, in_ready=1",
               in_ready, cnt_v, ret_ready, err, issued);
    end
    reset = 1'b0;
    exp_q.delete(); mon_q.delete();
    exp_issued = 0; exp_done = 0; exp_max = '0; exp_err = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt_v !== 1'b0) begin errors++; $display("FAIL rmid_fifo_empty cnt_v=%b need 0", cnt_v); end
    push(2, 8'h99);
    wait_resp(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_timeout got=%0d need=1", mon_q.size()); end
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      o = mon_q.pop_front(); e = exp_q.pop_front(); exp_done++;
      checks++;
      if (o.data !== e.data || o.lat !== e.lat) begin
        errors++;
        $display("FAIL rmid_resp data=%h lat=%0d need data=%h lat=%0d", o.data, o.lat, e.data, e.lat);
      end
    end
    checks++;
    if (issued !== SW'(1) || done !== SW'(1) || max_lat !== SW'(3) || err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_stats issued=%0d done=%0d max=%0d err=%b need 1 1 3 0", issued, done, max_lat, err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_cycles();
    test_back_to_back();
    test_stall();
    test_random();
    test_fault();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
